// File: rtl/alu_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_scheduler_if
// Brief    : Request, shared-alu and response bundle of the alu scheduler.
//            slave  = scheduler side, master = requesters / alu / consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_scheduler_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int CNTW = 16
);
    // requester side
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*4-1:0]  req_sel;
    // shared alu
    logic [31:0]        alu_in1;
    logic [31:0]        alu_in2;
    logic [3:0]         alu_sel;
    logic [31:0]        alu_out;
    logic               alu_over;
    logic               alu_under;
    // response channel
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_data;
    logic               resp_over;
    logic               resp_under;
    // status
    logic               sticky_over;
    logic               sticky_under;
    logic               clr_sticky;
    logic [CNTW-1:0]    ops_done;

    modport slave (
        input  req_valid, req_a, req_b, req_sel,
        input  alu_out, alu_over, alu_under,
        input  resp_ready, clr_sticky,
        output req_ready, alu_in1, alu_in2, alu_sel,
        output resp_valid, resp_id, resp_data, resp_over, resp_under,
        output sticky_over, sticky_under, ops_done
    );

    modport master (
        output req_valid, req_a, req_b, req_sel,
        output alu_out, alu_over, alu_under,
        output resp_ready, clr_sticky,
        input  req_ready, alu_in1, alu_in2, alu_sel,
        input  resp_valid, resp_id, resp_data, resp_over, resp_under,
        input  sticky_over, sticky_under, ops_done
    );
endinterface
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_scheduler
// Brief    : Round-robin sharing of one combinational 32-bit alu between NREQ
//            requesters; one operation in flight, tagged valid/ready result,
//            sticky overflow/underflow flags and a completed-op counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_scheduler #(
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int CNTW = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_scheduler_if.slave bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_tag;
    logic [31:0]     r_in1;
    logic [31:0]     r_in2;
    logic [3:0]      r_sel;
    logic            r_resp_valid;
    logic [IDW-1:0]  r_resp_id;
    logic [31:0]     r_resp_data;
    logic            r_resp_over;
    logic            r_resp_under;
    logic            r_sticky_over;
    logic            r_sticky_under;
    logic [CNTW-1:0] r_ops_done;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_idx;
    logic [IDW-1:0]  w_scan;
    logic            w_found;
    logic            w_accept;
    logic            w_resp_done;

    // Round-robin search: first valid requester starting one past the last grant
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_scan      = '0;
        w_found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && bus.req_valid[w_scan]) begin
                w_found         = 1'b1;
                w_grant[w_scan] = 1'b1;
                w_grant_idx     = w_scan;
            end
        end
    end

    // Grants are only offered while idle, so any offered grant is an accept
    assign w_accept    = (r_state == c_st_idle) && w_found;
    assign w_resp_done = (r_state == c_st_resp) && r_resp_valid && bus.resp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> EXEC -> RESP -> IDLE, holding in RESP until consumed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_nxt = c_st_exec;
            c_st_exec: w_state_nxt = c_st_resp;
            c_st_resp: if (w_resp_done) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Operand capture on accept and result capture after the single exec cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= IDW'(NREQ - 1);
            r_tag        <= '0;
            r_in1        <= '0;
            r_in2        <= '0;
            r_sel        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_resp_over  <= 1'b0;
            r_resp_under <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in1    <= bus.req_a[32*w_grant_idx +: 32];
                r_in2    <= bus.req_b[32*w_grant_idx +: 32];
                r_sel    <= bus.req_sel[4*w_grant_idx +: 4];
                r_tag    <= w_grant_idx;
                r_rr_ptr <= w_grant_idx;
            end
            if (r_state == c_st_exec) begin
                r_resp_data  <= bus.alu_out;
                r_resp_over  <= bus.alu_over;
                r_resp_under <= bus.alu_under;
                r_resp_id    <= r_tag;
                r_resp_valid <= 1'b1;
            end else if (w_resp_done) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    // Status: clear of the sticky bits wins over a coincident setting response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_over  <= 1'b0;
            r_sticky_under <= 1'b0;
            r_ops_done     <= '0;
        end else begin
            if (w_resp_done) begin
                r_ops_done <= r_ops_done + 1'b1;
            end
            if (bus.clr_sticky) begin
                r_sticky_over  <= 1'b0;
                r_sticky_under <= 1'b0;
            end else if (w_resp_done) begin
                r_sticky_over  <= r_sticky_over  | r_resp_over;
                r_sticky_under <= r_sticky_under | r_resp_under;
            end
        end
    end

    assign bus.req_ready    = (r_state == c_st_idle) ? w_grant : '0;
    assign bus.alu_in1      = r_in1;
    assign bus.alu_in2      = r_in2;
    assign bus.alu_sel      = r_sel;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_id      = r_resp_id;
    assign bus.resp_data    = r_resp_data;
    assign bus.resp_over    = r_resp_over;
    assign bus.resp_under   = r_resp_under;
    assign bus.sticky_over  = r_sticky_over;
    assign bus.sticky_under = r_sticky_under;
    assign bus.ops_done     = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_scheduler
// Brief    : Self-checking bench for alu_scheduler: directed scenarios plus a
//            randomized phase against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_scheduler;

    localparam int c_nreq = 3;
    localparam int c_idw  = 2;
    localparam int c_cntw = 8;
    localparam int c_wrap = 1 << c_cntw;

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_mul = 4'd2;
    localparam logic [3:0] c_op_and = 4'd3;
    localparam logic [3:0] c_op_or  = 4'd4;
    localparam logic [3:0] c_op_xor = 4'd5;
    localparam logic [3:0] c_op_lt  = 4'd6;

    localparam longint c_smax = 64'sd2147483647;
    localparam longint c_smin = -c_smax - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_scheduler_if #(.NREQ(c_nreq), .IDW(c_idw), .CNTW(c_cntw)) bus ();

    alu_scheduler #(.NREQ(c_nreq), .IDW(c_idw), .CNTW(c_cntw)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0]       op_a [c_nreq];
    logic [31:0]       op_b [c_nreq];
    logic [3:0]        op_s [c_nreq];
    logic [c_nreq-1:0] mask;

    // reference model state
    int m_rr;
    int m_ops;
    bit m_so;
    bit m_su;

    // Behavioural alu: exact signed arithmetic, flags from range of true result
    function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
        longint r;
        logic [31:0] o;
        bit ov;
        bit un;
        r  = 0;
        ov = 1'b0;
        un = 1'b0;
        case (s)
            c_op_add: r = longint'($signed(a)) + longint'($signed(b));
            c_op_sub: r = longint'($signed(a)) - longint'($signed(b));
            c_op_mul: r = longint'($signed(a)) * longint'($signed(b));
            c_op_and: r = longint'(a & b);
            c_op_or:  r = longint'(a | b);
            c_op_xor: r = longint'(a ^ b);
            c_op_lt:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            default:  r = 0;
        endcase
        if (s == c_op_add || s == c_op_sub || s == c_op_mul) begin
            ov = (r > c_smax);
            un = (r < c_smin);
        end
        o = r[31:0];
        return {ov, un, o};
    endfunction

    assign {bus.alu_over, bus.alu_under, bus.alu_out} = alu_f(bus.alu_in1, bus.alu_in2, bus.alu_sel);

    function automatic int model_grant(input int rr, input logic [c_nreq-1:0] m);
        for (int k = 1; k <= c_nreq; k++) begin
            if (m[(rr + k) % c_nreq]) return (rr + k) % c_nreq;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < c_nreq; i++) begin
            bus.req_a[32*i +: 32] = op_a[i];
            bus.req_b[32*i +: 32] = op_b[i];
            bus.req_sel[4*i +: 4] = op_s[i];
        end
        bus.req_valid = mask;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] s);
        op_a[i] = a;
        op_b[i] = b;
        op_s[i] = s;
        mask[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_rr  = c_nreq - 1;
        m_ops = 0;
        m_so  = 1'b0;
        m_su  = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":req_ready"},    bus.req_ready, 0);
        chk({tag, ":alu_in1"},      bus.alu_in1, 0);
        chk({tag, ":alu_in2"},      bus.alu_in2, 0);
        chk({tag, ":alu_sel"},      bus.alu_sel, 0);
        chk({tag, ":resp_valid"},   bus.resp_valid, 0);
        chk({tag, ":resp_id"},      bus.resp_id, 0);
        chk({tag, ":resp_data"},    bus.resp_data, 0);
        chk({tag, ":resp_flags"},   {bus.resp_over, bus.resp_under}, 0);
        chk({tag, ":sticky"},       {bus.sticky_over, bus.sticky_under}, 0);
        chk({tag, ":ops_done"},     bus.ops_done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mask = '0;
        drive();
        bus.resp_ready = 1'b0;
        bus.clr_sticky = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        model_reset();
    endtask

    // One full transaction from an idle negedge to the negedge after consumption.
    // keep=1 leaves the granted requester valid with a fresh random operation.
    task automatic do_op(input int stall, input bit clr, input bit keep, input string tag);
        int g;
        logic [33:0] e;
        drive();
        #1;
        g = model_grant(m_rr, mask);
        if (g < 0) begin
            $display("FAIL %s: bench issued no valid request", tag);
            $fatal(1);
        end
        chk({tag, ":grant"}, bus.req_ready, 64'(1) << g);
        e = alu_f(op_a[g], op_b[g], op_s[g]);
        m_rr = g;
        @(negedge clk);
        chk({tag, ":exec_ready"}, bus.req_ready, 0);
        chk({tag, ":exec_valid"}, bus.resp_valid, 0);
        chk({tag, ":alu_in1"}, bus.alu_in1, op_a[g]);
        chk({tag, ":alu_in2"}, bus.alu_in2, op_b[g]);
        chk({tag, ":alu_sel"}, bus.alu_sel, op_s[g]);
        if (keep) begin
            op_a[g] = rnd_word();
            op_b[g] = rnd_word();
            op_s[g] = 4'($urandom_range(0, 15));
        end else begin
            mask[g] = 1'b0;
        end
        drive();
        @(negedge clk);
        chk({tag, ":resp_valid"}, bus.resp_valid, 1);
        chk({tag, ":resp_id"},    bus.resp_id, g);
        chk({tag, ":resp_data"},  bus.resp_data, e[31:0]);
        chk({tag, ":resp_flags"}, {bus.resp_over, bus.resp_under}, e[33:32]);
        chk({tag, ":resp_ready0"}, bus.req_ready, 0);
        repeat (stall) begin
            @(negedge clk);
            chk({tag, ":hold_valid"}, bus.resp_valid, 1);
            chk({tag, ":hold_data"},  {bus.resp_id, bus.resp_over, bus.resp_under, bus.resp_data},
                                      {2'(g), e[33:32], e[31:0]});
            chk({tag, ":hold_ready"}, bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        bus.clr_sticky = clr;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.clr_sticky = 1'b0;
        m_ops = (m_ops + 1) % c_wrap;
        if (clr) begin
            m_so = 1'b0;
            m_su = 1'b0;
        end else begin
            m_so = m_so | e[33];
            m_su = m_su | e[32];
        end
        chk({tag, ":done_valid"},   bus.resp_valid, 0);
        chk({tag, ":ops_done"},     bus.ops_done, m_ops);
        chk({tag, ":sticky_over"},  bus.sticky_over, m_so);
        chk({tag, ":sticky_under"}, bus.sticky_under, m_su);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < c_nreq; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
            op_s[i] = '0;
        end
        mask = '0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_sel    = '0;
        bus.resp_ready = 1'b0;
        bus.clr_sticky = 1'b0;

        // signed overflow on ADD from requester 0
        do_reset();
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, c_op_add);
        do_op(0, 1'b0, 1'b0, "t1_add");
        chk("t1:sticky_over_set", bus.sticky_over, 1);

        // two requesters valid every cycle: grants alternate, req1 SUB underflows
        do_reset();
        set_op(0, 32'h0000_0005, 32'h0000_0003, c_op_add);
        set_op(1, 32'h8000_0000, 32'h0000_0001, c_op_sub);
        for (int n = 0; n < 4; n++) do_op(0, 1'b0, 1'b1, "t2_rr");
        mask = '0;

        // consumer stalls five cycles on an overflowing MUL
        set_op(0, 32'h0001_0000, 32'h0001_0000, c_op_mul);
        do_op(5, 1'b0, 1'b0, "t3_mul");

        // reset while the AND is executing: discarded, everything cleared
        set_op(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, c_op_and);
        drive();
        #1;
        chk("t5:grant", bus.req_ready, 64'(1) << model_grant(m_rr, mask));
        @(negedge clk);
        chk("t5:exec_valid", bus.resp_valid, 0);
        rst = 1'b1;
        mask = '0;
        drive();
        @(negedge clk);
        chk_zero("t5_rst");
        rst = 1'b0;
        model_reset();
        set_op(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, c_op_and);
        set_op(1, 32'h1234_5678, 32'h0000_0001, c_op_xor);
        do_op(0, 1'b0, 1'b0, "t5_after");
        do_op(0, 1'b0, 1'b0, "t5_next");

        // signed compare and an undefined opcode
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, c_op_lt);
        do_op(0, 1'b0, 1'b0, "t6_lt");
        set_op(2, 32'hDEAD_BEEF, 32'h1234_5678, 4'hF);
        do_op(1, 1'b0, 1'b0, "t6_undef");

        // request raised and withdrawn before any clock edge is never accepted
        mask = '0;
        drive();
        @(negedge clk);
        chk("drop:idle_ready", bus.req_ready, 0);
        set_op(1, 32'h0000_0001, 32'h0000_0001, c_op_add);
        drive();
        #1;
        chk("drop:offer", bus.req_ready, 64'(1) << model_grant(m_rr, mask));
        #2;
        mask = '0;
        drive();
        #1;
        chk("drop:withdrawn", bus.req_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("drop:no_resp", bus.resp_valid, 0);
        chk("drop:ops_same", bus.ops_done, m_ops);

        // randomized traffic until the counter is two below wrap
        guard = 0;
        while (m_ops != c_wrap - 2 && guard < 2000) begin
            for (int i = 0; i < c_nreq; i++) begin
                if (!mask[i] && $urandom_range(0, 1) == 1)
                    set_op(i, rnd_word(), rnd_word(), 4'($urandom_range(0, 15)));
            end
            if (mask == '0)
                set_op($urandom_range(0, c_nreq - 1), rnd_word(), rnd_word(),
                       4'($urandom_range(0, 15)));
            do_op($urandom_range(0, 2), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                  "rand");
            guard++;
        end
        chk("rand:reached_target", m_ops, c_wrap - 2);

        // clear beats a coincident overflow, and the counter wraps to zero
        mask = '0;
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, c_op_add);
        do_op(0, 1'b0, 1'b0, "t4_set");
        chk("t4:ops_max", bus.ops_done, c_wrap - 1);
        chk("t4:sticky_before", bus.sticky_over, 1);
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, c_op_add);
        do_op(0, 1'b1, 1'b0, "t4_clr");
        chk("t4:ops_wrapped", bus.ops_done, 0);
        chk("t4:sticky_cleared", bus.sticky_over, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
